mul_sequencer: RTL and testbench

MUL_SEQUENCER -- requirements
Module: mul_sequencer

---
 rtl/mul_sequencer_pkg.sv | 17 +
 rtl/mul_sequencer_if.sv | 36 +++
 rtl/mul_sequencer_seq_timer.sv | 25 ++
 rtl/mul_sequencer.sv | 105 ++++++++++
 tb/tb_mul_sequencer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mul_sequencer_pkg.sv
// rtl/mul_sequencer_pkg.sv - shared state encoding and display constants for mul_sequencer
package mul_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        LOAD,
        SHOW,
        ERROR
    } seq_state_e;

    localparam int BCD_WIDTH = 20;
    // Wide enough to index any digit-level scroll position of the BCD shifter.
    localparam int POS_W = $clog2(BCD_WIDTH);

endpackage

// File: rtl/mul_sequencer_if.sv
// rtl/mul_sequencer_if.sv - operand, multiplier and shifter signals of mul_sequencer
interface mul_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             go;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             a_neg;
    logic             b_neg;
    logic             mul_done;
    logic             scroll_l;
    logic             scroll_r;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic             mul_start;
    logic             mul_rst;
    logic             sr_load;
    logic             sr_en;
    logic             sr_dir;
    logic             neg;
    logic             busy;
    logic             valid;
    logic             err;

    modport master (
        input  go, a_mag, b_mag, a_neg, b_neg, mul_done, scroll_l, scroll_r,
        output mul_a, mul_b, mul_start, mul_rst, sr_load, sr_en, sr_dir,
               neg, busy, valid, err
    );

    modport slave (
        output go, a_mag, b_mag, a_neg, b_neg, mul_done, scroll_l, scroll_r,
        input  mul_a, mul_b, mul_start, mul_rst, sr_load, sr_en, sr_dir,
               neg, busy, valid, err
    );
endinterface

// File: rtl/mul_sequencer_seq_timer.sv
// rtl/mul_sequencer_seq_timer.sv - cycle counter that flags the last permitted wait cycle
module seq_timer #(
    parameter int LIMIT = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    // count holds completed cycles, so the current cycle is number count+1.
    assign expired = enable && (count == CW'(LIMIT - 1));
endmodule

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - sequences a multiply, loads the BCD shifter and handles scrolling
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 2 * WIDTH + 4,
    parameter int POS_MAX = 1
) (
    input  logic           clk,
    input  logic           rst,
    mul_sequencer_if.master bus
);
    seq_state_e       state;
    logic [POS_W-1:0] pos;
    logic [WIDTH-1:0] mul_a, mul_b;
    logic             mul_start, mul_rst, sr_load, sr_en, sr_dir;
    logic             neg, busy, valid, err;
    logic             expired;

    seq_timer #(.LIMIT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != WAIT),
        .enable  (state == WAIT),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pos       <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_start <= 1'b0;
            mul_rst   <= 1'b1;
            sr_load   <= 1'b0;
            sr_en     <= 1'b0;
            sr_dir    <= 1'b0;
            neg       <= 1'b0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            err       <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            mul_rst   <= 1'b0;
            sr_load   <= 1'b0;
            sr_en     <= 1'b0;
            sr_dir    <= 1'b0;
            case (state)
                IDLE, SHOW, ERROR: begin
                    if (bus.go) begin
                        mul_a     <= bus.a_mag;
                        mul_b     <= bus.b_mag;
                        neg       <= bus.a_neg ^ bus.b_neg;
                        err       <= 1'b0;
                        valid     <= 1'b0;
                        busy      <= 1'b1;
                        pos       <= '0;
                        mul_start <= 1'b1;
                        state     <= START;
                    end else if (state == SHOW && (bus.scroll_l != bus.scroll_r)) begin
                        if (bus.scroll_l && pos < POS_W'(POS_MAX)) begin
                            sr_en  <= 1'b1;
                            sr_dir <= 1'b1;
                            pos    <= pos + POS_W'(1);
                        end else if (bus.scroll_r && pos != '0) begin
                            sr_en  <= 1'b1;
                            pos    <= pos - POS_W'(1);
                        end
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    if (bus.mul_done) begin
                        sr_load <= 1'b1;
                        state   <= LOAD;
                    end else if (expired) begin
                        err     <= 1'b1;
                        mul_rst <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ERROR;
                    end
                end
                LOAD: begin
                    busy  <= 1'b0;
                    valid <= 1'b1;
                    state <= SHOW;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mul_a     = mul_a;
    assign bus.mul_b     = mul_b;
    assign bus.mul_start = mul_start;
    assign bus.mul_rst   = mul_rst;
    assign bus.sr_load   = sr_load;
    assign bus.sr_en     = sr_en;
    assign bus.sr_dir    = sr_dir;
    assign bus.neg       = neg;
    assign bus.busy      = busy;
    assign bus.valid     = valid;
    assign bus.err       = err;
endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - directed bench for mul_sequencer with a timeline reference model
module tb_mul_sequencer;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 2 * WIDTH + 4;
    localparam int POS_MAX = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul_sequencer_if #(.WIDTH(WIDTH)) bus ();

    mul_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .POS_MAX(POS_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Reference model: tracks how long ago a request was accepted rather than a state.
    logic             m_active, m_loaded, m_shown, m_err, m_neg;
    logic             m_start_p, m_load_p, m_rst_p, m_en, m_dir;
    logic [WIDTH-1:0] m_a, m_b;
    int               m_age, m_pos;

    always @(posedge clk) begin
        m_start_p <= 1'b0;
        m_load_p  <= 1'b0;
        m_rst_p   <= 1'b0;
        m_en      <= 1'b0;
        m_dir     <= 1'b0;
        if (rst) begin
            m_active <= 1'b0; m_loaded <= 1'b0; m_shown <= 1'b0; m_err <= 1'b0;
            m_neg <= 1'b0; m_a <= '0; m_b <= '0; m_age <= 0; m_pos <= 0;
            m_rst_p <= 1'b1;
        end else if (!m_active && bus.go) begin
            m_active <= 1'b1; m_loaded <= 1'b0; m_shown <= 1'b0; m_err <= 1'b0;
            m_age <= 1; m_pos <= 0; m_start_p <= 1'b1;
            m_a <= bus.a_mag; m_b <= bus.b_mag; m_neg <= bus.a_neg ^ bus.b_neg;
        end else if (m_active) begin
            if (m_loaded) begin
                m_active <= 1'b0; m_loaded <= 1'b0; m_shown <= 1'b1;
            end else if (m_age >= 2 && bus.mul_done) begin
                m_loaded <= 1'b1; m_load_p <= 1'b1;
            end else if (m_age - 1 == TIMEOUT) begin
                m_active <= 1'b0; m_err <= 1'b1; m_rst_p <= 1'b1;
            end else begin
                m_age <= m_age + 1;
            end
        end else if (m_shown && (bus.scroll_l ^ bus.scroll_r)) begin
            if (bus.scroll_l && m_pos < POS_MAX) begin
                m_en <= 1'b1; m_dir <= 1'b1; m_pos <= m_pos + 1;
            end else if (bus.scroll_r && m_pos > 0) begin
                m_en <= 1'b1; m_pos <= m_pos - 1;
            end
        end
    end

    wire logic [24:0] dut_vec = {bus.mul_a, bus.mul_b, bus.mul_start, bus.mul_rst, bus.sr_load,
                                 bus.sr_en, bus.sr_dir, bus.neg, bus.busy, bus.valid, bus.err};
    wire logic [24:0] mdl_vec = {m_a, m_b, m_start_p, m_rst_p, m_load_p,
                                 m_en, m_dir, m_neg, m_active, m_shown, m_err};

    int   n_cmp = 0, n_bad = 0, cyc = 0;
    int   n_start = 0, n_load = 0, n_en_l = 0, n_en_r = 0, n_mrst = 0;
    int   start_cyc = 0, load_cyc = 0, err_cyc = 0;
    logic err_prev = 1'b0, chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (chk_en) begin
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_bad++;
                $display("FAIL outputs at cycle %0d: got %h expected %h", cyc, dut_vec, mdl_vec);
            end
        end
        if (bus.mul_start) begin n_start++; start_cyc = cyc; end
        if (bus.sr_load) begin n_load++; load_cyc = cyc; end
        if (bus.sr_en && bus.sr_dir) n_en_l++;
        if (bus.sr_en && !bus.sr_dir) n_en_r++;
        if (bus.mul_rst) n_mrst++;
        if (bus.err && !err_prev) err_cyc = cyc;
        err_prev = bus.err;
    endtask

    int s_cyc, w_cyc, snap_start, snap_load, snap_l, snap_r, snap_rst;

    initial begin
        bus.go = 0; bus.a_mag = 0; bus.b_mag = 0; bus.a_neg = 0; bus.b_neg = 0;
        bus.mul_done = 0; bus.scroll_l = 0; bus.scroll_r = 0;
        step();
        chk_en = 1'b1;
        step();
        check("rst_mul_rst", bus.mul_rst, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.valid, 0);
        check("rst_mul_a", bus.mul_a, 0);
        rst = 0;
        step();
        check("post_rst_mul_rst", bus.mul_rst, 0);

        // 6 x 7, negative result, done 16 cycles after start
        snap_start = n_start; snap_load = n_load;
        bus.a_mag = 6; bus.b_mag = 7; bus.a_neg = 1; bus.b_neg = 0; bus.go = 1;
        step();
        bus.go = 0; s_cyc = cyc;
        check("go_start", bus.mul_start, 1);
        check("go_busy", bus.busy, 1);
        check("go_mul_a", bus.mul_a, 6);
        check("go_mul_b", bus.mul_b, 7);
        check("go_neg", bus.neg, 1);
        repeat (16) step();
        bus.mul_done = 1;
        step();
        bus.mul_done = 0;
        check("load_latency", load_cyc - s_cyc, 17);
        check("load_pulse", bus.sr_load, 1);
        step();
        check("show_valid", bus.valid, 1);
        check("show_neg", bus.neg, 1);
        check("show_busy", bus.busy, 0);
        check("start_pulses", n_start - snap_start, 1);
        check("load_pulses", n_load - snap_load, 1);

        // Scroll left three times, then right twice, against the one-position limit
        snap_l = n_en_l; snap_r = n_en_r;
        repeat (3) begin bus.scroll_l = 1; step(); bus.scroll_l = 0; step(); end
        check("scroll_l_pulses", n_en_l - snap_l, 1);
        check("scroll_l_no_r", n_en_r - snap_r, 0);
        snap_l = n_en_l; snap_r = n_en_r;
        repeat (2) begin bus.scroll_r = 1; step(); bus.scroll_r = 0; step(); end
        check("scroll_r_pulses", n_en_r - snap_r, 1);
        check("scroll_r_no_l", n_en_l - snap_l, 0);

        snap_l = n_en_l; snap_r = n_en_r;
        bus.scroll_l = 1; bus.scroll_r = 1;
        step();
        bus.scroll_l = 0; bus.scroll_r = 0;
        step();
        check("both_scroll", (n_en_l - snap_l) + (n_en_r - snap_r), 0);

        // go wins over a same-cycle scroll
        snap_start = n_start;
        bus.a_mag = 3; bus.b_mag = 5; bus.a_neg = 1; bus.b_neg = 1; bus.go = 1; bus.scroll_l = 1;
        step();
        bus.go = 0; bus.scroll_l = 0;
        check("go_scroll_start", bus.mul_start, 1);
        check("go_scroll_no_en", bus.sr_en, 0);
        check("go_scroll_mul_a", bus.mul_a, 3);
        check("go_scroll_neg", bus.neg, 0);
        step();
        snap_l = n_en_l; snap_r = n_en_r;
        bus.scroll_l = 1; step(); bus.scroll_l = 0; bus.scroll_r = 1; step(); bus.scroll_r = 0;
        check("wait_scroll", (n_en_l - snap_l) + (n_en_r - snap_r), 0);
        bus.a_mag = 9; bus.go = 1;
        step();
        bus.go = 0;
        check("wait_go_ignored_a", bus.mul_a, 3);
        check("wait_go_busy", bus.busy, 1);
        check("wait_go_starts", n_start - snap_start, 1);

        // Reset while waiting, then a late done
        snap_load = n_load;
        rst = 1; step(); rst = 0; step();
        bus.mul_done = 1; step(); bus.mul_done = 0;
        repeat (3) step();
        check("abort_no_load", n_load - snap_load, 0);
        check("abort_outputs", dut_vec, 0);

        // Timeout; a done during START must be ignored
        snap_rst = n_mrst; snap_load = n_load;
        bus.a_mag = 2; bus.b_mag = 4; bus.a_neg = 0; bus.b_neg = 0; bus.go = 1;
        step();
        bus.go = 0; bus.mul_done = 1;
        step();
        bus.mul_done = 0; w_cyc = cyc; err_cyc = 0;
        for (int i = 0; i < 40 && !bus.err; i++) step();
        check("timeout_cycles", err_cyc - w_cyc, TIMEOUT);
        check("timeout_err", bus.err, 1);
        check("timeout_busy", bus.busy, 0);
        check("timeout_mul_rst_pulses", n_mrst - snap_rst, 1);
        check("timeout_no_load", n_load - snap_load, 0);
        repeat (3) step();
        check("error_hold", bus.err, 1);

        bus.a_mag = 15; bus.b_mag = 1; bus.go = 1;
        step();
        bus.go = 0; s_cyc = cyc;
        check("recover_err_clear", bus.err, 0);
        check("recover_start", bus.mul_start, 1);
        step();
        bus.mul_done = 1;
        step();
        bus.mul_done = 0;
        check("recover_latency", load_cyc - s_cyc, 2);
        step();
        check("recover_valid", bus.valid, 1);
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
